// File: rtl/seg7_pkg.sv
// Shared constants for the bus-mapped seven-segment controller: register map
// helpers, control bit positions, the hex segment table and blank patterns.
package seg7_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  localparam int CTRL_EN_BIT = 7;
  localparam int CTRL_B_MSB  = 3;
  localparam logic [7:0] CTRL_WMASK = 8'h8F;
  localparam logic [7:0] CTRL_RESET = 8'h8F;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;

  // Active-low segments g..a for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int num_nib_regs(input int nd);
    return (nd + 1) / 2;
  endfunction

  function automatic int off_dp(input int nr);
    return nr;
  endfunction

  function automatic int off_en(input int nr);
    return nr + 1;
  endfunction

  function automatic int off_blink(input int nr);
    return nr + 2;
  endfunction

  function automatic int off_ctrl(input int nr);
    return nr + 3;
  endfunction

  function automatic int num_regs(input int nr);
    return nr + 4;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal-point to active-low segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp_on,
  output logic [7:0] seg_n
);

  always_comb begin
    seg_n = {~dp_on, HEX_SEG[nibble]};
  end

endmodule

// File: rtl/seg7_mux_periph.sv
// Bus-mapped multi-digit seven-segment controller with PWM brightness and
// per-digit blink; scans one digit per slot and drives active-low outputs.
module seg7_mux_periph
  import seg7_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hD0,
  parameter int         NUM_DIGITS  = 4,
  parameter int         REFRESH_DIV = 50000,
  parameter int         BLINK_SCANS = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  inout  wire  [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  output logic [NUM_DIGITS-1:0] SEG_SELECT,
  output logic [7:0]            DEC_OUT
);

  localparam int NR        = num_nib_regs(NUM_DIGITS);
  localparam int NUM_REGS  = num_regs(NR);
  localparam int OFF_DP    = off_dp(NR);
  localparam int OFF_EN    = off_en(NR);
  localparam int OFF_BLINK = off_blink(NR);
  localparam int OFF_CTRL  = off_ctrl(NR);
  localparam int PRESC_DIV = REFRESH_DIV / 16;
  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(BLINK_SCANS + 1);
  localparam logic [7:0] DMASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ALL_OFF[NUM_DIGITS-1:0];

  if (int'(BASE_ADDR) + NUM_REGS > 256) begin : g_bad_map
    $error("seg7_mux_periph: register map runs past address 8'hFF");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_mux_periph: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 16 || (REFRESH_DIV % 16) != 0 || BLINK_SCANS < 1) begin : g_bad_timing
    $error("seg7_mux_periph: bad REFRESH_DIV or BLINK_SCANS");
  end

  logic [7:0] nib_q [NR];
  logic [7:0] nib_d [NR];
  logic [7:0] dp_q, dp_d, en_q, en_d, blink_q, blink_d, ctrl_q, ctrl_d;
  logic [7:0] rd_data_q, rd_data_d, rd_val;
  logic       rd_en_q, rd_en_d;
  logic [7:0] off;
  logic       addr_hit;

  // Bus cycle: the address/BUS_WE pair is qualified every edge. An in-range
  // write commits at that edge; an in-range read drives BUS_DATA for exactly
  // the following cycle with the pre-edge value; otherwise the bus floats.
  always_comb begin
    off      = BUS_ADDR - BASE_ADDR;
    addr_hit = (BUS_ADDR >= BASE_ADDR) && (off < 8'(NUM_REGS));
  end

  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NR; k++) begin
      if (off == 8'(k)) rd_val = nib_q[k];
    end
    if (off == 8'(OFF_DP))    rd_val = dp_q;
    if (off == 8'(OFF_EN))    rd_val = en_q;
    if (off == 8'(OFF_BLINK)) rd_val = blink_q;
    if (off == 8'(OFF_CTRL))  rd_val = ctrl_q;
  end

  always_comb begin
    nib_d   = nib_q;
    dp_d    = dp_q;
    en_d    = en_q;
    blink_d = blink_q;
    ctrl_d  = ctrl_q;
    if (addr_hit && BUS_WE) begin
      for (int k = 0; k < NR; k++) begin
        if (off == 8'(k)) nib_d[k] = BUS_DATA;
      end
      if (off == 8'(OFF_DP))    dp_d    = BUS_DATA & DMASK;
      if (off == 8'(OFF_EN))    en_d    = BUS_DATA & DMASK;
      if (off == 8'(OFF_BLINK)) blink_d = BUS_DATA & DMASK;
      if (off == 8'(OFF_CTRL))  ctrl_d  = BUS_DATA & CTRL_WMASK;
    end
    rd_en_d   = addr_hit && !BUS_WE;
    rd_data_d = rd_val;
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 8'hzz;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      nib_q     <= '{default: 8'h00};
      dp_q      <= 8'h00;
      en_q      <= DMASK;
      blink_q   <= 8'h00;
      ctrl_q    <= CTRL_RESET;
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      nib_q     <= nib_d;
      dp_q      <= dp_d;
      en_q      <= en_d;
      blink_q   <= blink_d;
      ctrl_q    <= ctrl_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
    end
  end

  scan_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    phase_q, phase_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Reset lands directly in SCAN because CTRL resets with the enable set,
  // which lets the first lit digit appear one cycle after reset release.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_SCAN;
      presc_q       <= '0;
      phase_q       <= 4'd0;
      digit_q       <= '0;
      scan_cnt_q    <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      phase_q       <= phase_d;
      digit_q       <= digit_d;
      scan_cnt_q    <= scan_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  always_comb begin
    state_d = ctrl_q[CTRL_EN_BIT] ? ST_SCAN : ST_IDLE;
  end

  always_comb begin
    presc_d       = '0;
    phase_d       = 4'd0;
    digit_d       = '0;
    scan_cnt_d    = '0;
    blink_phase_d = 1'b0;
    if (state_q == ST_SCAN) begin
      presc_d       = presc_q + PW'(1);
      phase_d       = phase_q;
      digit_d       = digit_q;
      scan_cnt_d    = scan_cnt_q;
      blink_phase_d = blink_phase_q;
      if (presc_q == PW'(PRESC_DIV - 1)) begin
        presc_d = '0;
        phase_d = phase_q + 4'd1;
        if (phase_q == 4'd15) begin
          digit_d = digit_q + DW'(1);
          if (digit_q == DW'(NUM_DIGITS - 1)) begin
            digit_d    = '0;
            scan_cnt_d = scan_cnt_q + SW'(1);
            if (scan_cnt_q == SW'(BLINK_SCANS - 1)) begin
              scan_cnt_d    = '0;
              blink_phase_d = ~blink_phase_q;
            end
          end
        end
      end
    end
  end

  logic [3:0]            nib_sel;
  logic                  dp_sel, en_sel, blink_sel, lit;
  logic [7:0]            dec_pat, dec_d, dec_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;

  seg7_hex_decode u_decode (
    .nibble (nib_sel),
    .dp_on  (dp_sel),
    .seg_n  (dec_pat)
  );

  // Outputs are built from live register contents so writes show next cycle.
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    en_sel    = 1'b0;
    blink_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q == DW'(k)) begin
        nib_sel   = nib_q[k / 2][(k % 2) * 4 +: 4];
        dp_sel    = dp_q[k];
        en_sel    = en_q[k];
        blink_sel = blink_q[k];
      end
    end
    lit = (state_q == ST_SCAN) && ctrl_q[CTRL_EN_BIT] &&
          (phase_q <= ctrl_q[CTRL_B_MSB:0]) && en_sel &&
          !(blink_sel && blink_phase_q);
    an_d  = lit ? ~(NUM_DIGITS'(1) << digit_q) : AN_OFF;
    dec_d = lit ? dec_pat : SEG_BLANK;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      an_q  <= AN_OFF;
      dec_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      dec_q <= dec_d;
    end
  end

  assign SEG_SELECT = an_q;
  assign DEC_OUT    = dec_q;

endmodule

// File: tb/tb_seg7_mux_periph.sv
// Randomised bench for seg7_mux_periph: a time-based reference model predicts
// every output cycle and every bus read; a monitor compares on the falling edge.
module tb_seg7_mux_periph;

  localparam int ND = 4;
  localparam int RD = 32;
  localparam int BS = 2;
  localparam int NREG = 6;
  localparam logic [7:0] BASE = 8'hD0;

  localparam logic [6:0] HEX_TB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk = 1'b0;
  logic          rst;
  wire  [7:0]    bus_data;
  logic [7:0]    bus_addr;
  logic          bus_we;
  logic          tb_drive;
  logic [7:0]    tb_wdata;
  logic [ND-1:0] seg_select;
  logic [7:0]    dec_out;

  assign bus_data = tb_drive ? tb_wdata : 8'hzz;
  pullup pu_bus (bus_data);

  always #5 clk = ~clk;

  seg7_mux_periph #(
    .BASE_ADDR   (BASE),
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLINK_SCANS (BS)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .BUS_DATA   (bus_data),
    .BUS_ADDR   (bus_addr),
    .BUS_WE     (bus_we),
    .SEG_SELECT (seg_select),
    .DEC_OUT    (dec_out)
  );

  // Scoreboard state
  logic [ND+7:0] exp_q[$];
  logic [7:0]    rd_exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: register shadow plus elapsed scan time
  logic [7:0] sh_reg [NREG];
  int t = 0;
  int off = 0;
  bit scan_on = 1'b0;
  bit started = 1'b0;
  bit rd_resp = 1'b0;
  bit in_range = 1'b0;
  bit en_next = 1'b0;

  function automatic logic [ND+7:0] exp_disp();
    int d, ph, sc;
    bit bp, lit;
    logic [7:0] pair, seg;
    logic [3:0] nib;
    logic [ND-1:0] an;
    d  = (t / RD) % ND;
    ph = (t % RD) / (RD / 16);
    sc = t / (RD * ND);
    bp = ((sc / BS) % 2) == 1;
    pair = sh_reg[d / 2] >> (4 * (d % 2));
    nib  = pair[3:0];
    lit = scan_on && sh_reg[5][7] && (ph <= int'(sh_reg[5][3:0])) &&
          sh_reg[3][d] && !(sh_reg[4][d] && bp);
    an  = ~(ND'(1) << d);
    seg = {~sh_reg[2][d], HEX_TB[nib]};
    return lit ? {an, seg} : {{ND{1'b1}}, 8'hFF};
  endfunction

  function automatic logic [7:0] write_mask(input int o);
    if (o < 2) return 8'hFF;
    if (o < 5) return 8'h0F;
    return 8'h8F;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.push_back({{ND{1'b1}}, 8'hFF});
        sh_reg  = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h8F};
        scan_on = 1'b1;
        t       = 0;
        rd_resp = 1'b0;
        started = 1'b1;
      end else if (started) begin
        exp_q.push_back(exp_disp());
        off      = int'(bus_addr) - int'(BASE);
        in_range = (off >= 0) && (off < NREG);
        rd_resp  = in_range && !bus_we;
        if (rd_resp) rd_exp_q.push_back(sh_reg[off]);
        en_next = sh_reg[5][7];
        if (in_range && bus_we) sh_reg[off] = tb_wdata & write_mask(off);
        t = scan_on ? t + 1 : 0;
        scan_on = en_next;
      end
    end
  end

  // Monitor
  initial begin
    logic [ND+7:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("display", 16'({seg_select, dec_out}), 16'(e));
      end
      if (started && !tb_drive) begin
        if (rd_resp) begin
          if (rd_exp_q.size() > 0) check("bus_read", 16'(bus_data), 16'(rd_exp_q.pop_front()));
        end else begin
          check("bus_hiz", 16'(bus_data), 16'h00FF);
        end
      end
    end
  end

  // Driver tasks: each starts and ends just after a rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a;
    bus_we   = 1'b1;
    tb_wdata = d;
    tb_drive = 1'b1;
    cycles(1);
    bus_we   = 1'b0;
    tb_drive = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a);
    bus_addr = a;
    bus_we   = 1'b0;
    cycles(1);
    bus_addr = 8'h00;
    cycles(1);
  endtask

  initial begin
    rst      = 1'b1;
    bus_addr = 8'h00;
    bus_we   = 1'b0;
    tb_drive = 1'b0;
    tb_wdata = 8'h00;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    for (int a = 0; a < NREG; a++) bus_read(BASE + 8'(a));

    bus_write(8'hD0, 8'h21);
    bus_write(8'hD1, 8'hF8);
    bus_write(8'hD2, 8'h01);
    cycles(4 * RD + 10);
    bus_read(8'hD1);
    bus_read(8'hE0);

    bus_write(8'hD5, 8'h83);
    cycles(4 * RD);
    bus_write(8'hD4, 8'h02);
    cycles(2 * 4 * RD * BS + 40);
    bus_write(8'hD3, 8'h0E);
    cycles(4 * RD + 8);

    cycles($urandom_range(3, 40));
    bus_write(8'hD5, 8'h0F);
    cycles(10);
    bus_write(8'hD5, 8'h8F);
    cycles(4 * RD);

    cycles($urandom_range(5, 60));
    do_reset(1);
    cycles(8 * RD);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] a, dv;
      int sel;
      sel = $urandom_range(0, 39);
      a   = BASE + 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 8'($urandom);
      dv  = 8'($urandom);
      if (a == 8'hD5) dv[7] = ($urandom_range(0, 3) != 0);
      if (sel == 0) do_reset(1);
      else if (sel < 20) bus_write(a, dv);
      else bus_read(a);
      cycles($urandom_range(0, 12));
    end

    cycles(2);
    @(negedge clk);
    #1;
    check("queue_drain", 16'(exp_q.size() + rd_exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
